// File: rtl/trdb_pkg.sv
// Shared trace-debugger types: sync packet subformats and resync scheduler states.
package trdb_pkg;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2
    } sync_subformat_e;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_PENDING = 2'd1,
        RS_REQUEST = 2'd2,
        RS_ACK     = 2'd3
    } rs_state_e;

endpackage

// File: rtl/trdb_resync_scheduler.sv
// Schedules one format-3 sync request per trace-enable rise or resync threshold,
// anchored on the next retired instruction; restarts the resync counter on acceptance.
module trdb_resync_scheduler
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trace_enabled_i,
    input  logic            resync_max_i,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic            exception_i,
    input  logic            sync_ready_i,
    output logic            sync_valid_o,
    output logic [1:0]      sync_subformat_o,
    output logic [XLEN-1:0] sync_iaddr_o,
    output logic            resync_rst_o,
    output logic            busy_o
);

    localparam int unsigned HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    rs_state_e       state_q, state_d;
    logic            en_q;
    logic [HW-1:0]   holdoff_q, holdoff_d;
    logic            valid_q, valid_d;
    sync_subformat_e subformat_q, subformat_d;
    logic [XLEN-1:0] iaddr_q, iaddr_d;
    logic            rst_pulse_q, rst_pulse_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RS_IDLE;
            en_q        <= 1'b0;
            holdoff_q   <= '0;
            valid_q     <= 1'b0;
            subformat_q <= SF_START;
            iaddr_q     <= '0;
            rst_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= trace_enabled_i;
            holdoff_q   <= holdoff_d;
            valid_q     <= valid_d;
            subformat_q <= subformat_d;
            iaddr_q     <= iaddr_d;
            rst_pulse_q <= rst_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        holdoff_d   = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;
        valid_d     = valid_q;
        subformat_d = subformat_q;
        iaddr_d     = iaddr_q;
        rst_pulse_d = 1'b0;

        unique case (state_q)
            RS_IDLE: begin
                // A coincident rise and threshold collapse into a single request.
                if (trace_enabled_i && (!en_q || (resync_max_i && holdoff_q == '0))) begin
                    state_d = RS_PENDING;
                end
            end
            RS_PENDING: begin
                if (!trace_enabled_i) begin
                    state_d   = RS_IDLE;
                    holdoff_d = '0;
                end else if (inst_valid_i) begin
                    state_d     = RS_REQUEST;
                    valid_d     = 1'b1;
                    iaddr_d     = iaddr_i;
                    subformat_d = exception_i ? SF_TRAP : SF_START;
                end
            end
            RS_REQUEST: begin
                if (!trace_enabled_i) begin
                    state_d   = RS_IDLE;
                    valid_d   = 1'b0;
                    holdoff_d = '0;
                end else if (sync_ready_i) begin
                    state_d     = RS_ACK;
                    valid_d     = 1'b0;
                    rst_pulse_d = 1'b1;
                end
            end
            RS_ACK: begin
                state_d   = RS_IDLE;
                holdoff_d = HW'(HOLDOFF_CYCLES);
            end
            default: state_d = RS_IDLE;
        endcase
    end

    assign sync_valid_o     = valid_q;
    assign sync_subformat_o = subformat_q;
    assign sync_iaddr_o     = iaddr_q;
    assign resync_rst_o     = rst_pulse_q;
    assign busy_o           = (state_q != RS_IDLE);

endmodule

// File: tb/tb_trdb_resync_scheduler.sv
// Directed self-checking bench for trdb_resync_scheduler (XLEN=32, HOLDOFF_CYCLES=2).
module tb_trdb_resync_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        resync_max;
    logic        inst_valid;
    logic [31:0] iaddr;
    logic        exc;
    logic        ready;
    logic        valid;
    logic [1:0]  subformat;
    logic [31:0] sync_iaddr;
    logic        rst_pulse;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    trdb_resync_scheduler #(
        .XLEN           (32),
        .HOLDOFF_CYCLES (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .trace_enabled_i  (trace_en),
        .resync_max_i     (resync_max),
        .inst_valid_i     (inst_valid),
        .iaddr_i          (iaddr),
        .exception_i      (exc),
        .sync_ready_i     (ready),
        .sync_valid_o     (valid),
        .sync_subformat_o (subformat),
        .sync_iaddr_o     (sync_iaddr),
        .resync_rst_o     (rst_pulse),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        trace_en   = 1'b0;
        resync_max = 1'b0;
        inst_valid = 1'b0;
        iaddr      = '0;
        exc        = 1'b0;
        ready      = 1'b0;
        tick();
        tick();
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_sf", {30'd0, subformat}, 32'd0);
        chk("reset_iaddr", sync_iaddr, 32'd0);
        chk("reset_rst", {31'd0, rst_pulse}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Enable rise -> PENDING, anchor two cycles later, ready already high
        rst = 1'b0;
        tick();
        trace_en = 1'b1;
        tick();
        chk("rise_busy", {31'd0, busy}, 32'd1);
        chk("rise_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("pend_valid", {31'd0, valid}, 32'd0);
        inst_valid = 1'b1;
        iaddr      = 32'h8000_0000;
        ready      = 1'b1;
        tick();
        inst_valid = 1'b0;
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_sf", {30'd0, subformat}, 32'd0);
        chk("t1_iaddr", sync_iaddr, 32'h8000_0000);
        chk("t1_rst_early", {31'd0, rst_pulse}, 32'd0);
        tick();
        chk("t1_ack_valid", {31'd0, valid}, 32'd0);
        chk("t1_ack_rst", {31'd0, rst_pulse}, 32'd1);
        tick();
        chk("t1_rst_once", {31'd0, rst_pulse}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        tick();
        tick();

        // Steady threshold, ready withheld three cycles
        resync_max = 1'b1;
        ready      = 1'b0;
        tick();
        chk("t2_pend", {31'd0, busy}, 32'd1);
        inst_valid = 1'b1;
        iaddr      = 32'h0000_1234;
        tick();
        iaddr = 32'hdead_beef;
        chk("t2_valid", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, valid}, 32'd1);
            chk("t2_hold_iaddr", sync_iaddr, 32'h0000_1234);
            chk("t2_hold_sf", {30'd0, subformat}, 32'd0);
            chk("t2_hold_rst", {31'd0, rst_pulse}, 32'd0);
        end
        ready = 1'b1;
        tick();
        ready      = 1'b0;
        inst_valid = 1'b0;
        chk("t2_ack_rst", {31'd0, rst_pulse}, 32'd1);
        chk("t2_ack_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("t2_hold0_busy", {31'd0, busy}, 32'd0);
        chk("t2_hold0_rst", {31'd0, rst_pulse}, 32'd0);
        tick();
        chk("t2_hold1_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t2_hold2_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t2_rearm_busy", {31'd0, busy}, 32'd1);

        // Anchor on a trapping instruction
        resync_max = 1'b0;
        inst_valid = 1'b1;
        exc        = 1'b1;
        iaddr      = 32'h0000_0100;
        ready      = 1'b1;
        tick();
        inst_valid = 1'b0;
        exc        = 1'b0;
        chk("t3_valid", {31'd0, valid}, 32'd1);
        chk("t3_sf", {30'd0, subformat}, 32'd1);
        chk("t3_iaddr", sync_iaddr, 32'h0000_0100);
        tick();
        chk("t3_rst", {31'd0, rst_pulse}, 32'd1);
        tick();

        // Rise during holdoff; coincident instruction ignored; abort in REQUEST
        trace_en = 1'b0;
        ready    = 1'b0;
        tick();
        trace_en   = 1'b1;
        inst_valid = 1'b1;
        iaddr      = 32'h0000_0200;
        tick();
        inst_valid = 1'b0;
        chk("t4_pend", {31'd0, busy}, 32'd1);
        chk("t4_coinc_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("t4_still_pend", {31'd0, busy}, 32'd1);
        chk("t4_still_novalid", {31'd0, valid}, 32'd0);
        inst_valid = 1'b1;
        iaddr      = 32'h0000_0300;
        tick();
        inst_valid = 1'b0;
        chk("t4_valid", {31'd0, valid}, 32'd1);
        chk("t4_iaddr", sync_iaddr, 32'h0000_0300);
        trace_en = 1'b0;
        tick();
        chk("t4_abort_valid", {31'd0, valid}, 32'd0);
        chk("t4_abort_busy", {31'd0, busy}, 32'd0);
        chk("t4_abort_rst", {31'd0, rst_pulse}, 32'd0);
        tick();
        chk("t4_abort_rst2", {31'd0, rst_pulse}, 32'd0);

        // Rise and threshold together -> single START, single pulse
        trace_en   = 1'b1;
        resync_max = 1'b1;
        ready      = 1'b1;
        tick();
        chk("t5_pend", {31'd0, busy}, 32'd1);
        inst_valid = 1'b1;
        iaddr      = 32'h0000_0400;
        tick();
        inst_valid = 1'b0;
        chk("t5_valid", {31'd0, valid}, 32'd1);
        chk("t5_sf", {30'd0, subformat}, 32'd0);
        tick();
        chk("t5_rst", {31'd0, rst_pulse}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_single_rst", {31'd0, rst_pulse}, 32'd0);
            chk("t5_single_busy", {31'd0, busy}, 32'd0);
        end
        resync_max = 1'b0;

        // Reset while in REQUEST
        trace_en = 1'b0;
        ready    = 1'b0;
        tick();
        trace_en = 1'b1;
        tick();
        inst_valid = 1'b1;
        iaddr      = 32'h0000_0500;
        tick();
        inst_valid = 1'b0;
        chk("t6_valid", {31'd0, valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_valid0", {31'd0, valid}, 32'd0);
        chk("t6_sf0", {30'd0, subformat}, 32'd0);
        chk("t6_iaddr0", sync_iaddr, 32'd0);
        chk("t6_rst0", {31'd0, rst_pulse}, 32'd0);
        chk("t6_busy0", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
